// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state enum, BCD constants and clamp helper for the countdown timer
package timer_pkg;

  // Controller states of the countdown timer
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Saturate a nibble to the largest legal BCD digit
  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one borrow-linked BCD down-counting digit
module bcd_digit_cell
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       borrow_req_in,
  input  logic       can_borrow_in,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [3:0] digit,
  output logic       borrow_req_out,
  output logic       nonzero
);

  // A zero digit only wraps to 9 when a higher digit can actually supply the borrow
  always_ff @(posedge clk) begin
    if (!rst) begin
      digit <= BCD_ZERO;
    end else if (load) begin
      digit <= load_digit;
    end else if (borrow_req_in) begin
      if (digit != BCD_ZERO) begin
        digit <= digit - 4'd1;
      end else if (can_borrow_in) begin
        digit <= BCD_MAX;
      end
    end
  end

  assign nonzero        = (digit != BCD_ZERO);
  assign borrow_req_out = borrow_req_in & ~nonzero & can_borrow_in;

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - prescaled multi-digit BCD countdown timer; optional BCD_TIMER_AUTO_RELOAD_EN
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000,
  parameter int TICK_W     = $clog2(TICK_DIV + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    start,
  input  logic                    pause,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    zero,
  output logic                    timeout
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  timer_state_t            state, state_nxt;
  logic [TICK_W-1:0]       prescaler, presc_nxt;
  logic                    timeout_nxt;
  logic [NUM_DIGITS-1:0]   nonzero;
  logic [NUM_DIGITS-1:0]   can_borrow;
  logic [4*NUM_DIGITS-1:0] load_clamped;
  logic [4*NUM_DIGITS-1:0] cell_load_val;
  logic                    cell_load;
  logic                    tick;
  logic                    last_one;
  logic                    expire;
  logic                    reload;
  logic                    top_borrow;

  // Clamp every incoming nibble and work out which digits have a nonzero digit above them
  always_comb begin
    load_clamped = '0;
    can_borrow   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_clamped[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
      can_borrow[i]          = |(nonzero >> (i + 1));
    end
  end

  assign zero     = ~|nonzero;
  assign last_one = (digits[3:0] == 4'd1) && !can_borrow[0];
  assign tick     = (state == RUN) && !load && !pause && !zero && (prescaler == TICK_LAST);
  assign expire   = tick && last_one;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [4*NUM_DIGITS-1:0] stored;

  // Remember the last clamped start value so expiry can restart from it
  always_ff @(posedge clk) begin
    if (!rst) begin
      stored <= '0;
    end else if (load) begin
      stored <= load_clamped;
    end
  end

  assign reload        = expire && (stored != '0);
  assign cell_load_val = load ? load_clamped : stored;
`else
  assign reload        = 1'b0;
  assign cell_load_val = load_clamped;
`endif

  assign cell_load = load | reload;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_cell
    logic req_in;
    logic req_out;

    if (i == 0) begin : g_lsd
      assign req_in = tick;
    end else begin : g_upper
      assign req_in = g_cell[i-1].req_out;
    end

    if (i == NUM_DIGITS - 1) begin : g_msd
      assign top_borrow = req_out;
    end

    bcd_digit_cell u_cell (
      .clk            (clk),
      .rst            (rst),
      .borrow_req_in  (req_in),
      .can_borrow_in  (can_borrow[i]),
      .load           (cell_load),
      .load_digit     (cell_load_val[4*i +: 4]),
      .digit          (digits[4*i +: 4]),
      .borrow_req_out (req_out),
      .nonzero        (nonzero[i])
    );
  end

  // Next-state, prescaler and timeout decisions; load beats pause beats start beats tick
  always_comb begin
    state_nxt   = state;
    presc_nxt   = prescaler;
    timeout_nxt = 1'b0;
    if (load) begin
      state_nxt = IDLE;
      presc_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!pause && start) begin
            if (zero) begin
              state_nxt   = DONE;
              timeout_nxt = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_nxt = PAUSED;
          end else begin
            presc_nxt = (prescaler == TICK_LAST) ? '0 : prescaler + TICK_W'(1);
            if (expire) begin
              timeout_nxt = 1'b1;
              if (!reload) begin
                state_nxt = DONE;
              end
            end else if (top_borrow) begin
              // A borrow escaping the top digit means nothing is left to count
              state_nxt = DONE;
            end
          end
        end
        PAUSED: begin
          if (!pause && start) begin
            state_nxt = RUN;
          end
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Register controller state and all status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      prescaler <= '0;
      timeout   <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_nxt;
      prescaler <= presc_nxt;
      timeout   <= timeout_nxt;
      running   <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed-vector bench for bcd_countdown_timer
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld1, st1, pz1, ld4, st4, pz4;
  logic [15:0] lv1, lv4;
  logic [15:0] d1, d4;
  logic        run1, z1, to1, run4, z4, to4;
  int          n_vec  = 0;
  int          n_miss = 0;
  int          pulses;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.NUM_DIGITS(4), .TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .load(ld1), .load_val(lv1), .start(st1), .pause(pz1),
    .digits(d1), .running(run1), .zero(z1), .timeout(to1)
  );

  bcd_countdown_timer #(.NUM_DIGITS(4), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .load(ld4), .load_val(lv4), .start(st4), .pause(pz4),
    .digits(d4), .running(run4), .zero(z4), .timeout(to4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  initial begin
    rst = 1'b0;
    ld1 = 1'b0; st1 = 1'b0; pz1 = 1'b0; lv1 = 16'h0000;
    ld4 = 1'b0; st4 = 1'b0; pz4 = 1'b0; lv4 = 16'h0000;
    step();
    chk("rst_digits", d1, 16'h0000);
    chk("rst_running", run1, 0);
    chk("rst_zero", z1, 1);
    chk("rst_timeout", to1, 0);
    chk("rst_digits4", d4, 16'h0000);
    rst = 1'b1;

    // Prescaled run with pause/resume (TICK_DIV=4)
    ld4 = 1'b1; lv4 = 16'h0050; step();
    ld4 = 1'b0; st4 = 1'b1; step();
    chk("p4_start_run", run4, 1);
    chk("p4_start_digits", d4, 16'h0050);
    st4 = 1'b0;
    repeat (3) step();
    chk("p4_before_tick", d4, 16'h0050);
    step();
    chk("p4_first_tick", d4, 16'h0049);
    repeat (2) step();
    pz4 = 1'b1; step();
    chk("p4_paused_run", run4, 0);
    pz4 = 1'b0;
    repeat (10) step();
    chk("p4_hold_digits", d4, 16'h0049);
    chk("p4_hold_run", run4, 0);
    st4 = 1'b1; step();
    chk("p4_resume_run", run4, 1);
    chk("p4_resume_digits", d4, 16'h0049);
    st4 = 1'b0; step();
    chk("p4_resume_plus1", d4, 16'h0049);
    step();
    chk("p4_resume_plus2", d4, 16'h0048);
    repeat (3) step();
    chk("p4_pre_load", d4, 16'h0048);
    ld4 = 1'b1; lv4 = 16'h0777; step();
    chk("p4_load_beats_tick", d4, 16'h0777);
    chk("p4_load_idle", run4, 0);
    ld4 = 1'b0; step();
    chk("p4_idle_hold", d4, 16'h0777);

`ifndef BCD_TIMER_AUTO_RELOAD_EN
    // Full countdown from 0100 to expiry (TICK_DIV=1)
    ld1 = 1'b1; lv1 = 16'h0100; step();
    chk("load0100", d1, 16'h0100);
    chk("load0100_zero", z1, 0);
    ld1 = 1'b0; st1 = 1'b1; step();
    chk("start_running", run1, 1);
    chk("start_digits", d1, 16'h0100);
    st1 = 1'b0;
    pulses = 0;
    for (int v = 99; v >= 0; v--) begin
      step();
      chk("count", d1, to_bcd(v));
      if (to1) pulses++;
      if (v == 0) begin
        chk("expire_timeout", to1, 1);
        chk("expire_running", run1, 0);
        chk("expire_zero", z1, 1);
      end
    end
    st1 = 1'b1; step();
    if (to1) pulses++;
    chk("done_ignores_start", run1, 0);
    chk("done_digits", d1, 16'h0000);
    st1 = 1'b0;
    repeat (2) begin
      step();
      if (to1) pulses++;
    end
    chk("single_pulse", pulses, 1);
`endif

    // Triple borrow in one tick
    ld1 = 1'b1; lv1 = 16'h1000; step();
    ld1 = 1'b0; st1 = 1'b1; step();
    st1 = 1'b0; step();
    chk("triple_borrow", d1, 16'h0999);
    chk("triple_running", run1, 1);

    // Clamped load, then start and pause together
    ld1 = 1'b1; lv1 = 16'hA3F2; step();
    chk("clamp", d1, 16'h9392);
    ld1 = 1'b0; st1 = 1'b1; pz1 = 1'b1; step();
    chk("pause_wins_digits", d1, 16'h9392);
    chk("pause_wins_run", run1, 0);
    step();
    chk("pause_wins_hold", d1, 16'h9392);
    st1 = 1'b0; pz1 = 1'b0;

`ifndef BCD_TIMER_AUTO_RELOAD_EN
    // Start on a zero value goes straight to DONE with a pulse
    ld1 = 1'b1; lv1 = 16'h0000; step();
    chk("zero_load", z1, 1);
    ld1 = 1'b0; st1 = 1'b1; step();
    chk("zero_start_timeout", to1, 1);
    chk("zero_start_run", run1, 0);
    st1 = 1'b0; step();
    chk("zero_start_pulse_end", to1, 0);
`endif

    // Mid-run reset, then load and start together
    ld1 = 1'b1; lv1 = 16'h0020; step();
    ld1 = 1'b0; st1 = 1'b1; step();
    st1 = 1'b0; step();
    chk("midrun_count", d1, 16'h0019);
    rst = 1'b0; step();
    chk("midrun_rst_digits", d1, 16'h0000);
    chk("midrun_rst_running", run1, 0);
    chk("midrun_rst_zero", z1, 1);
    chk("midrun_rst_timeout", to1, 0);
    rst = 1'b1;
    ld1 = 1'b1; lv1 = 16'h0005; st1 = 1'b1; step();
    chk("load_start_digits", d1, 16'h0005);
    chk("load_start_run", run1, 0);
    ld1 = 1'b0; st1 = 1'b0; step();
    chk("load_start_idle", d1, 16'h0005);
    chk("load_start_idle_run", run1, 0);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    // Auto reload: 2,1,(0->2),1,(0->2)
    ld1 = 1'b1; lv1 = 16'h0002; step();
    ld1 = 1'b0; st1 = 1'b1; step();
    st1 = 1'b0; step();
    chk("ar_one", d1, 16'h0001);
    chk("ar_one_to", to1, 0);
    step();
    chk("ar_reload", d1, 16'h0002);
    chk("ar_reload_to", to1, 1);
    chk("ar_reload_run", run1, 1);
    step();
    chk("ar_one_b", d1, 16'h0001);
    chk("ar_one_b_to", to1, 0);
    step();
    chk("ar_reload_b", d1, 16'h0002);
    chk("ar_reload_b_to", to1, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised multi-digit BCD countdown timer built from a chain of borrow-linked digit cells.
- Loads a BCD start value, then decrements once per prescaled tick while running.
- Supports start, pause and resume; raises a one-cycle timeout pulse when the count expires.
- Feeds seven-segment display drivers and game/control FSMs in the same design.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (1..8); digit 0 is the least significant.
- TICK_DIV, 50000, clk cycles per decrement; must be ≥1. A value of 1 decrements every cycle while running.
- TICK_W, $clog2(TICK_DIV+1), prescaler counter width; derived, not to be overridden.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset; sampled on posedge clk.
- load  in  1  load load_val and go to IDLE; highest priority after rst.
- load_val  in  4*NUM_DIGITS  BCD start value; nibble i → digit i.
- start  in  1  begin or resume counting.
- pause  in  1  hold count; prescaler holds too.
- digits  out  4*NUM_DIGITS  current BCD value.
- running  out  1  high in RUN state.
- zero  out  1  high when all digits are 0.
- timeout  out  1  one-cycle pulse on expiry.

Behaviour:
- Reset (rst=0 at posedge):
  - digits=0, prescaler=0, state=IDLE.
  - running=0, timeout=0, zero=1.
- States: IDLE, RUN, PAUSED, DONE. All outputs are registered.
- Priority each cycle: rst > load > pause > start > tick.
- load, any state:
  - Each nibble greater than 9 is clamped to 9.
  - digits take the clamped value next cycle; prescaler=0; state=IDLE.
  - zero reflects the loaded value.
- IDLE:
  - start with zero=0 → RUN.
  - start with zero=1 → DONE with timeout pulse.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; a tick fires on the wrap cycle.
  - On a tick, digit 0 decrements.
  - Digit i at 0 requesting a borrow takes it from digit i+1 only if some higher digit is nonzero. It then wraps to 9 and forwards the borrow request upward.
  - The whole value decrements by exactly 1 per tick; there are no partial borrows.
  - A tick that makes the value 0 → next cycle: state DONE, timeout=1 for one cycle, running=0.
  - pause → PAUSED.
- PAUSED:
  - digits and prescaler hold.
  - start (with pause low) → RUN, continuing from the held prescaler value.
- DONE:
  - digits stay 0; no further ticks or pulses.
  - start is ignored; only load or rst leaves DONE.
- Simultaneous events:
  - start and pause both high → pause wins.
  - load and a tick in the same cycle → load wins and the tick is dropped.
- A mid-run rst clears everything within one cycle; no timeout is emitted.
- The count never wraps below 0, and digits never hold a value above 9.

Optional Feature:
- Macro: BCD_TIMER_AUTO_RELOAD_EN.
- Defined:
  - The last clamped load_val is stored in an internal register.
  - On expiry, timeout pulses, digits reload from the stored value on the same edge, and the state stays RUN (no DONE).
  - If the stored value is 0, the block enters DONE as normal.
- Undefined: no stored-value register; behaviour is as described above.

Decomposition:
- Shared package timer_pkg holds:
  - the state enum (IDLE, RUN, PAUSED, DONE);
  - BCD_MAX=4'd9 and BCD_ZERO=4'd0;
  - a clamp-to-BCD function.
- Sub-module bcd_digit_cell, one digit instantiated NUM_DIGITS times:
  - Inputs: borrow_req_in, can_borrow_in, load, load_digit.
  - Outputs: digit, borrow_req_out, nonzero.
  - Top level ORs the nonzero outputs of higher cells to form can_borrow.

Test Plan:
- NUM_DIGITS=4, TICK_DIV=1: load 0100, start → sequence 0100, 0099, 0098 …; timeout pulses exactly once, in the cycle after 0001→0000, then DONE.
- load 1000, start, 1 tick → 0999 (triple borrow in one tick); running stays 1.
- TICK_DIV=4: start, pause after 6 cycles, hold 10 cycles → digits and prescaler unchanged. Restart → next decrement 2 cycles later.
- load_val=16'hA3F2 → digits 9392 (clamped); start and pause together → state IDLE/PAUSED, no decrement.
- Mid-run: rst=0 for 1 cycle → digits 0, running 0, zero 1, no timeout. Then load 0005 with start in the same cycle → IDLE holding 0005.
- With BCD_TIMER_AUTO_RELOAD_EN: load 0002, start, TICK_DIV=1 → 2,1,0→2,1,0→2; timeout pulses every 2 ticks.
